// File: rtl/uart_tx_arbiter_if.sv
// Request/transmit bundle between the requesters, the arbiter and UART_TX.
// master = arbiter side, slave = requesters plus transmitter side.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    RF_RdData_Valid;
  logic [DATA_WIDTH-1:0]   RF_RdData;
  logic                    ALU_OUT_Valid;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    busy;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;

  modport master (
    input  RF_RdData_Valid, RF_RdData, ALU_OUT_Valid, ALU_OUT, busy,
    output TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RF_RdData_Valid, RF_RdData, ALU_OUT_Valid, ALU_OUT, busy,
    input  TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of UART_TX between RF read data (1 byte) and ALU result (2 bytes).
// Optional WAIT_HI timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.master bus,
  input  logic              clr_ovf,
  output logic              arb_busy,
  output logic              ovf,
  output logic              tmo_err
);

  if (TIMEOUT_CYC < 1) begin : g_tmo_chk
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} state_t;

  state_t                  state, state_nx;
  logic                    rf_full, alu_full;
  logic [DATA_WIDTH-1:0]   rf_buf;
  logic [2*DATA_WIDTH-1:0] alu_buf;
  logic                    grant_alu, grant_alu_nx;
  logic                    last_alu, last_alu_nx;
  logic                    byte_idx, byte_idx_nx;
  logic                    rf_free, alu_free;
  logic                    ovf_set;
  logic [DATA_WIDTH-1:0]   load_data;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_fire;
`endif

  always_comb begin
    state_nx     = state;
    grant_alu_nx = grant_alu;
    last_alu_nx  = last_alu;
    byte_idx_nx  = byte_idx;
    rf_free      = 1'b0;
    alu_free     = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    tmo_fire     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!bus.busy && (rf_full || alu_full)) begin
          state_nx     = LOAD;
          // ALU wins when alone, or on a tie when RF was served last
          grant_alu_nx = alu_full && (!rf_full || !last_alu);
          last_alu_nx  = grant_alu_nx;
          byte_idx_nx  = 1'b0;
        end
      end
      LOAD: state_nx = WAIT_HI;
      WAIT_HI: begin
        if (bus.busy) begin
          state_nx = WAIT_LO;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          tmo_fire = 1'b1;
          state_nx = IDLE;
          rf_free  = !grant_alu;
          alu_free = grant_alu;
        end
`endif
      end
      WAIT_LO: begin
        if (!bus.busy) begin
          if (grant_alu && !byte_idx) begin
            byte_idx_nx = 1'b1;
            state_nx    = LOAD;
          end else begin
            rf_free  = !grant_alu;
            alu_free = grant_alu;
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    load_data = rf_buf;
    if (grant_alu_nx) begin
      load_data = byte_idx_nx ? alu_buf[2*DATA_WIDTH-1:DATA_WIDTH]
                              : alu_buf[DATA_WIDTH-1:0];
    end
  end

  // A buffer released on this edge may take a new request on the same edge
  assign ovf_set = (bus.RF_RdData_Valid && rf_full && !rf_free) ||
                   (bus.ALU_OUT_Valid && alu_full && !alu_free);

  assign arb_busy = rf_full || alu_full || (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      grant_alu     <= 1'b0;
      last_alu      <= 1'b1;
      byte_idx      <= 1'b0;
      rf_full       <= 1'b0;
      alu_full      <= 1'b0;
      rf_buf        <= '0;
      alu_buf       <= '0;
      ovf           <= 1'b0;
      bus.TX_P_DATA <= '0;
      bus.TX_D_VLD  <= 1'b0;
    end else begin
      state     <= state_nx;
      grant_alu <= grant_alu_nx;
      last_alu  <= last_alu_nx;
      byte_idx  <= byte_idx_nx;

      if (bus.RF_RdData_Valid && (!rf_full || rf_free)) begin
        rf_buf  <= bus.RF_RdData;
        rf_full <= 1'b1;
      end else if (rf_free) begin
        rf_full <= 1'b0;
      end

      if (bus.ALU_OUT_Valid && (!alu_full || alu_free)) begin
        alu_buf  <= bus.ALU_OUT;
        alu_full <= 1'b1;
      end else if (alu_free) begin
        alu_full <= 1'b0;
      end

      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end

      bus.TX_D_VLD <= (state_nx == LOAD);
      if (state_nx == LOAD) begin
        bus.TX_P_DATA <= load_data;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
      tmo_err <= 1'b0;
    end else begin
      tmo_cnt <= (state == WAIT_HI && state_nx == WAIT_HI) ? tmo_cnt + 1'b1 : '0;
      if (tmo_fire) begin
        tmo_err <= 1'b1;
      end else if (clr_ovf) begin
        tmo_err <= 1'b0;
      end
    end
  end
`else
  assign tmo_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter with a behavioural UART_TX busy model.
module tb_uart_tx_arbiter;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr_ovf = 1'b0;
  logic arb_busy, ovf, tmo_err;

  uart_tx_arbiter_if #(.DATA_WIDTH(DW)) bus();

  uart_tx_arbiter #(.DATA_WIDTH(DW), .TIMEOUT_CYC(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .clr_ovf  (clr_ovf),
    .arb_busy (arb_busy),
    .ovf      (ovf),
    .tmo_err  (tmo_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic model_en = 1'b1;
  logic pend = 1'b0;
  int   bcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor: every TX_D_VLD cycle pops one expected byte
  always @(negedge clk) begin
    if (bus.TX_D_VLD === 1'b1) begin
      if (model_en) pend = 1'b1;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tx: got %02h expected no pulse", bus.TX_P_DATA);
      end else begin
        e = q.pop_front();
        if (bus.TX_P_DATA !== e.b) begin
          bad++;
          $display("FAIL tx_byte: got %02h expected %02h", bus.TX_P_DATA, e.b);
        end
        if (e.c >= 0) begin
          total++;
          if (cyc != e.c) begin
            bad++;
            $display("FAIL tx_cycle(%02h): got %0d expected %0d", e.b, cyc, e.c);
          end
        end
      end
    end
  end

  // UART_TX model: busy rises 1 cycle after Data_Valid and stays high 11 cycles
  initial begin
    bus.busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pend) begin
        pend     = 1'b0;
        bus.busy = 1'b1;
        bcnt     = 11;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) bus.busy = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rv, input logic [7:0] rd,
                     input logic av, input logic [15:0] ad, input logic clr);
    bus.RF_RdData_Valid = rv;
    bus.RF_RdData       = rd;
    bus.ALU_OUT_Valid   = av;
    bus.ALU_OUT         = ad;
    clr_ovf             = clr;
    step();
    bus.RF_RdData_Valid = 1'b0;
    bus.ALU_OUT_Valid   = 1'b0;
    clr_ovf             = 1'b0;
  endtask

  task automatic push(input logic [7:0] b, input int c);
    exp_t x;
    x.b = b;
    x.c = c;
    q.push_back(x);
  endtask

  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (q.size() == 0 && !arb_busy && !bus.busy && bcnt == 0 && !pend) done = 1'b1;
    end
    chk(name, done, 1'b1);
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #2;
      if (bus.busy === lvl) seen = 1'b1;
    end
    chk(name, seen, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen_at;
    bus.RF_RdData_Valid = 1'b0;
    bus.RF_RdData       = '0;
    bus.ALU_OUT_Valid   = 1'b0;
    bus.ALU_OUT         = '0;

    // Reset state
    repeat (3) step();
    chk("rst_tx_data", bus.TX_P_DATA, 8'h00);
    chk("rst_tx_vld", bus.TX_D_VLD, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_tmo", tmo_err, 1'b0);
    chk("rst_arb_busy", arb_busy, 1'b0);
    rst = 1'b1;
    repeat (2) step();

    // Single RF byte, latency 2
    n = cyc;
    push(8'hA5, n + 2);
    req(1'b1, 8'hA5, 1'b0, 16'h0, 1'b0);
    chk("arb_busy_rf", arb_busy, 1'b1);
    wait_drain("drain_rf");
    chk("arb_busy_idle", arb_busy, 1'b0);

    // ALU two bytes, low first, second right after busy falls
    n = cyc;
    push(8'h34, n + 2);
    push(8'h12, n + 15);
    req(1'b0, 8'h00, 1'b1, 16'h1234, 1'b0);
    wait_drain("drain_alu");
    chk("ovf_after_alu", ovf, 1'b0);

    // Simultaneous pair straight after reset: RF wins the first tie
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    n = cyc;
    push(8'h11, n + 2);
    push(8'hEF, n + 16);
    push(8'hBE, n + 29);
    req(1'b1, 8'h11, 1'b1, 16'hBEEF, 1'b0);
    wait_drain("drain_pair1");

    // Overflow while pending, set beats clear, then clear
    push(8'h66, cyc + 2);
    req(1'b1, 8'h66, 1'b0, 16'h0, 1'b0);
    chk("ovf_before_drop", ovf, 1'b0);
    req(1'b1, 8'h77, 1'b0, 16'h0, 1'b0);
    chk("ovf_set", ovf, 1'b1);
    req(1'b1, 8'h88, 1'b0, 16'h0, 1'b1);
    chk("ovf_set_wins", ovf, 1'b1);
    wait_drain("drain_ovf");
    chk("ovf_sticky", ovf, 1'b1);
    req(1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
    chk("ovf_cleared", ovf, 1'b0);

    // Tie after an RF grant: ALU goes first
    n = cyc;
    push(8'h02, n + 2);
    push(8'h01, n + 15);
    push(8'h22, n + 29);
    req(1'b1, 8'h22, 1'b1, 16'h0102, 1'b0);
    wait_drain("drain_pair2");

    // New request on the same edge the buffer is freed: accepted, no ovf
    push(8'h3C, cyc + 2);
    req(1'b1, 8'h3C, 1'b0, 16'h0, 1'b0);
    wait_busy(1'b1, "busy_rise_3c");
    wait_busy(1'b0, "busy_fall_3c");
    push(8'h5A, cyc + 2);
    bus.RF_RdData       = 8'h5A;
    bus.RF_RdData_Valid = 1'b1;
    step();
    bus.RF_RdData_Valid = 1'b0;
    chk("ovf_free_edge", ovf, 1'b0);
    wait_drain("drain_free_edge");
    chk("ovf_free_edge_end", ovf, 1'b0);

    // Reset during WAIT_LO of ALU byte 0: second byte never sent
    push(8'hCD, cyc + 2);
    req(1'b0, 8'h00, 1'b1, 16'hABCD, 1'b0);
    wait_busy(1'b1, "busy_rise_abcd");
    repeat (3) step();
    rst      = 1'b0;
    bcnt     = 0;
    pend     = 1'b0;
    bus.busy = 1'b0;
    #1;
    chk("midrst_tx_vld", bus.TX_D_VLD, 1'b0);
    chk("midrst_tx_data", bus.TX_P_DATA, 8'h00);
    chk("midrst_arb_busy", arb_busy, 1'b0);
    chk("midrst_ovf", ovf, 1'b0);
    repeat (2) step();
    rst = 1'b1;
    repeat (30) step();
    chk("midrst_queue_empty", q.size(), 0);
    chk("midrst_idle", arb_busy, 1'b0);

`ifdef UART_ARB_TIMEOUT_EN
    // busy never rises: timeout within 5 cycles of TX_D_VLD
    model_en = 1'b0;
    n = cyc;
    push(8'h99, n + 2);
    req(1'b1, 8'h99, 1'b0, 16'h0, 1'b0);
    seen_at = -1;
    for (int i = 0; i < 10 && seen_at < 0; i++) begin
      step();
      if (tmo_err === 1'b1) seen_at = cyc;
    end
    chk("tmo_seen", (seen_at >= 0), 1'b1);
    chk("tmo_within_5", (seen_at >= 0 && seen_at - (n + 2) <= 5), 1'b1);
    chk("tmo_idle", arb_busy, 1'b0);
    req(1'b0, 8'h00, 1'b0, 16'h0, 1'b1);
    chk("tmo_cleared", tmo_err, 1'b0);
    model_en = 1'b1;
    push(8'hC3, cyc + 2);
    req(1'b1, 8'hC3, 1'b0, 16'h0, 1'b0);
    wait_drain("drain_after_tmo");
    chk("tmo_stays_clear", tmo_err, 1'b0);
`else
    seen_at = 0;
    chk("tmo_tied_low", tmo_err, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Sequences the UART transmitter and shares it between two on-chip requesters: register-file read data (1 byte) and ALU result (2 bytes).
Each request is captured in a one-entry holding buffer, arbitrated round-robin, and serialised as single-cycle Data_Valid pulses paced by the transmitter's busy.
Sits between the system controller datapath and UART_TX, in the UART clock domain.

Parameters:
DATA_WIDTH, 8, UART byte width; the ALU result is 2*DATA_WIDTH.
TIMEOUT_CYC, 4, cycles to wait for busy to rise after a Data_Valid pulse (used only with UART_ARB_TIMEOUT_EN).

Ports:
clk  in  1  clock; one clock domain, all logic on the rising edge.
rst  in  1  asynchronous active-low reset.
RF_RdData_Valid  in  1  single-cycle pulse; RF_RdData is valid.
RF_RdData  in  DATA_WIDTH  register-file read byte.
ALU_OUT_Valid  in  1  single-cycle pulse; ALU_OUT is valid.
ALU_OUT  in  2*DATA_WIDTH  ALU result.
busy  in  1  UART_TX busy.
TX_P_DATA  out  DATA_WIDTH  byte to UART_TX P_DATA.
TX_D_VLD  out  1  one-cycle pulse to UART_TX Data_Valid.
arb_busy  out  1  high when any buffer is full or the FSM is not in IDLE.
ovf  out  1  sticky flag: a request was dropped.
clr_ovf  in  1  synchronous clear of ovf.
tmo_err  out  1  sticky timeout flag; cleared by clr_ovf.

Behaviour:
- Reset (rst low, asynchronous):
  - TX_P_DATA=0, TX_D_VLD=0, ovf=0, tmo_err=0.
  - Both buffers empty; FSM in IDLE; last_grant=ALU, so the RF requester wins the first tie.
- Capture:
  - Valid pulse with its buffer empty: data latched and the buffer marked full on the same edge.
  - Valid pulse with its buffer full: data dropped and ovf set next cycle. The held data is unchanged.
  - Both valids in the same cycle are captured independently.
  - A buffer freed on the same edge that a new valid arrives accepts the new data, with no ovf.
- FSM states: IDLE, LOAD, WAIT_HI, WAIT_LO.
- IDLE:
  - Enter LOAD when busy=0 and at least one buffer is full.
  - Grant: if only one buffer is full, it wins; if both, the requester other than last_grant wins.
  - Grant updates last_grant and sets byte_idx=0.
- LOAD (1 cycle):
  - TX_D_VLD=1; TX_P_DATA = RF byte, ALU_OUT[7:0] for byte_idx=0, or ALU_OUT[15:8] for byte_idx=1.
  - Go to WAIT_HI.
  - TX_D_VLD is registered, so it is high exactly one cycle, 2 cycles after the request pulse when idle.
- WAIT_HI: stay until busy=1, then go to WAIT_LO.
- WAIT_LO: stay until busy=0, then:
  - ALU with byte_idx=0: set byte_idx=1 and go to LOAD directly, with no re-arbitration between the two ALU bytes.
  - Otherwise: free the granted buffer and go to IDLE.
- TX_P_DATA holds its last value outside LOAD.
- clr_ovf and a new overflow in the same cycle: ovf stays set (set wins).
- Reset mid-transfer aborts the transfer, empties both buffers and drops TX_D_VLD immediately.
- busy=1 while in IDLE: no launch until it deasserts.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_HI.
  - If busy has not risen after TIMEOUT_CYC cycles: set tmo_err, free the granted buffer (an ALU transfer is abandoned whole), return to IDLE.
- Undefined:
  - No counter; WAIT_HI waits indefinitely.
  - tmo_err is tied to 0.

Test Plan:
- RF request 0xA5; busy rises 1 cycle after TX_D_VLD and falls 11 cycles later -> TX_D_VLD=1 with TX_P_DATA=0xA5 exactly one cycle, 2 cycles after the valid; arb_busy low after busy falls.
- ALU request 0x1234 -> two pulses, 0x34 then 0x12; second pulse in the cycle after busy falls; no ovf.
- RF 0x11 and ALU 0xBEEF in the same cycle after reset -> order 0x11, 0xEF, 0xBE; a following simultaneous pair RF 0x22 and ALU 0x0102 -> order 0x02, 0x01, 0x22.
- Second RF pulse 0x77 while 0x66 is pending -> 0x66 sent, 0x77 never sent, ovf=1; clr_ovf pulse -> ovf=0.
- rst low during WAIT_LO of ALU byte 0 -> outputs at reset values, no second byte sent after release.
- UART_ARB_TIMEOUT_EN defined, busy held 0, TIMEOUT_CYC=4 -> tmo_err=1 within 5 cycles of TX_D_VLD; FSM back in IDLE; next request serviced normally.
